// File: rtl/ring_pkg.sv
// ring_pkg: shared types and helpers for the ring counter monitor.
//   state_t    - monitor FSM states
//   is_onehot  - true when exactly one bit of the vector is set
//   rot_next   - legal successor of a ring state (rotate left by one within w bits)
// Vectors are passed zero-extended to RING_MAX_W bits so one helper serves any ring width.
package ring_pkg;

   localparam int unsigned RING_MAX_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   function automatic logic is_onehot(input logic [RING_MAX_W-1:0] v);
      return (v != '0) && ((v & (v - RING_MAX_W'(1))) == '0);
   endfunction

   // Rotate left by one within the low w bits; bit w-1 wraps into bit 0.
   function automatic logic [RING_MAX_W-1:0] rot_next(input logic [RING_MAX_W-1:0] v,
                                                      input int unsigned         w);
      logic [RING_MAX_W-1:0] mask;
      mask = (w >= RING_MAX_W) ? '1 : ((RING_MAX_W'(1) << w) - RING_MAX_W'(1));
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: combinational one-hot to binary encoder.
//   onehot  in   WIDTH  one-hot vector
//   pos_c   out  IDX_W  index of the lowest set bit (meaningful only for one-hot input)
module ring_onehot_enc #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] pos_c
);

   // Scan from the top down so the lowest set bit wins.
   always_comb begin
      pos_c = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (onehot[i]) pos_c = IDX_W'(i);
      end
   end

endmodule

// File: rtl/ring_monitor.sv
// ring_monitor: checks and decodes a one-hot ring counter.
//   clk        in   clock, rising edge
//   clear      in   asynchronous active-low reset
//   en         in   sample strobe for ring_in
//   ring_in    in   ring counter state (WIDTH bits)
//   rev_clr    in   synchronous clear of rev_count (wins over an increment)
//   idx        out  binary position of the set bit
//   valid      out  idx meaningful (monitor locked)
//   locked     out  FSM in LOCKED
//   onehot_err out  1-cycle pulse: sample not one-hot
//   seq_err    out  1-cycle pulse: one-hot sample is not the expected successor
//   rev_count  out  completed revolutions, saturating
// All outputs are registered: a sample at edge N is reflected after edge N.
module ring_monitor
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned CNT_W      = 8,
   parameter bit          ALLOW_HOLD = 1'b0
) (
   input  logic                       clk,
   input  logic                       clear,
   input  logic                       en,
   input  logic [WIDTH-1:0]           ring_in,
   input  logic                       rev_clr,
   output logic [$clog2(WIDTH)-1:0]   idx,
   output logic                       valid,
   output logic                       locked,
   output logic                       onehot_err,
   output logic                       seq_err,
   output logic [CNT_W-1:0]           rev_count
);

   localparam int unsigned IDX_W = $clog2(WIDTH);

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   cur;
   logic [WIDTH-1:0]   cur_next;
   logic [WIDTH-1:0]   expected_c;
   logic [IDX_W-1:0]   pos_c;
   logic [IDX_W-1:0]   idx_next;
   logic               sample_onehot_c;
   logic               onehot_err_next;
   logic               seq_err_next;
   logic               rev_inc;

   ring_onehot_enc #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_enc (
      .onehot (ring_in),
      .pos_c  (pos_c)
   );

   assign sample_onehot_c = is_onehot(RING_MAX_W'(ring_in));
   assign expected_c      = WIDTH'(rot_next(RING_MAX_W'(cur), WIDTH));

   // FSM state register.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= IDLE;
      else        state <= state_next;
   end

   // Next state, next datapath values and error pulses.
   always_comb begin
      state_next      = state;
      cur_next        = cur;
      idx_next        = idx;
      onehot_err_next = 1'b0;
      seq_err_next    = 1'b0;
      rev_inc         = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (sample_onehot_c) begin
                  state_next = LOCKED;
                  cur_next   = ring_in;
                  idx_next   = pos_c;
               end else begin
                  onehot_err_next = 1'b1;
               end
            end
            LOCKED: begin
               if (!sample_onehot_c) begin
                  // Lose lock; idx keeps its last value.
                  onehot_err_next = 1'b1;
                  state_next      = IDLE;
               end else if (ring_in == expected_c) begin
                  cur_next = ring_in;
                  idx_next = pos_c;
                  rev_inc  = cur[WIDTH-1];
               end else if (ring_in == cur) begin
                  seq_err_next = !ALLOW_HOLD;
               end else begin
                  // Out-of-order step: flag it and re-lock on the new position.
                  seq_err_next = 1'b1;
                  cur_next     = ring_in;
                  idx_next     = pos_c;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cur        <= '0;
         idx        <= '0;
         valid      <= 1'b0;
         locked     <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         cur        <= cur_next;
         idx        <= idx_next;
         valid      <= (state_next == LOCKED);
         locked     <= (state_next == LOCKED);
         onehot_err <= onehot_err_next;
         seq_err    <= seq_err_next;
      end
   end

   // Saturating revolution counter; rev_clr wins over an increment.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         rev_count <= '0;
      end else if (rev_clr) begin
         rev_count <= '0;
      end else if (rev_inc && (rev_count != '1)) begin
         rev_count <= rev_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ring_monitor.sv
// tb_ring_monitor: self-checking bench for ring_monitor.
// Three instances share stimulus: default, ALLOW_HOLD=1, and CNT_W=2.
// A behavioural model tracks lock / position / revolution count per instance.
module tb_ring_monitor;

   logic       clk = 1'b0;
   logic       clear;
   logic       en;
   logic       rev_clr;
   logic [3:0] ring_in;

   logic [1:0] idx_o    [3];
   logic       valid_o  [3];
   logic       locked_o [3];
   logic       oe_o     [3];
   logic       se_o     [3];
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic [1:0] cnt2;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   bit m_lock [3];
   int m_pos  [3];
   int m_cnt  [3];
   bit m_oe   [3];
   bit m_se   [3];
   int m_hold [3] = '{0, 1, 0};
   int m_cmax [3] = '{255, 255, 3};

   always #5 clk = ~clk;

   ring_monitor #(.WIDTH(4), .CNT_W(8), .ALLOW_HOLD(1'b0)) dut0 (
      .clk(clk), .clear(clear), .en(en), .ring_in(ring_in), .rev_clr(rev_clr),
      .idx(idx_o[0]), .valid(valid_o[0]), .locked(locked_o[0]),
      .onehot_err(oe_o[0]), .seq_err(se_o[0]), .rev_count(cnt0));

   ring_monitor #(.WIDTH(4), .CNT_W(8), .ALLOW_HOLD(1'b1)) dut1 (
      .clk(clk), .clear(clear), .en(en), .ring_in(ring_in), .rev_clr(rev_clr),
      .idx(idx_o[1]), .valid(valid_o[1]), .locked(locked_o[1]),
      .onehot_err(oe_o[1]), .seq_err(se_o[1]), .rev_count(cnt1));

   ring_monitor #(.WIDTH(4), .CNT_W(2), .ALLOW_HOLD(1'b0)) dut2 (
      .clk(clk), .clear(clear), .en(en), .ring_in(ring_in), .rev_clr(rev_clr),
      .idx(idx_o[2]), .valid(valid_o[2]), .locked(locked_o[2]),
      .onehot_err(oe_o[2]), .seq_err(se_o[2]), .rev_count(cnt2));

   function automatic int get_cnt(input int k);
      case (k)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_lock[k] = 0; m_pos[k] = 0; m_cnt[k] = 0; m_oe[k] = 0; m_se[k] = 0;
      end
   endtask

   // One sample per the rotation rules, expressed on positions rather than bit vectors.
   task automatic model_step(input bit e, input logic [3:0] r, input bit c);
      int ones;
      int p;
      bit inc;
      ones = 0;
      p    = 0;
      for (int b = 3; b >= 0; b--) if (r[b]) begin ones++; p = b; end
      for (int k = 0; k < 3; k++) begin
         inc     = 0;
         m_oe[k] = 0;
         m_se[k] = 0;
         if (e) begin
            if (ones != 1) begin
               m_oe[k]   = 1;
               m_lock[k] = 0;
            end else if (!m_lock[k]) begin
               m_lock[k] = 1;
               m_pos[k]  = p;
            end else if (p == (m_pos[k] + 1) % 4) begin
               inc      = (m_pos[k] == 3);
               m_pos[k] = p;
            end else if (p == m_pos[k]) begin
               m_se[k] = (m_hold[k] == 0);
            end else begin
               m_se[k]  = 1;
               m_pos[k] = p;
            end
         end
         if (c) m_cnt[k] = 0;
         else if (inc && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
      end
   endtask

   task automatic step(input bit e, input logic [3:0] r, input bit c);
      en      = e;
      ring_in = r;
      rev_clr = c;
      @(posedge clk);
      model_step(e, r, c);
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b0; en = 1'b0; ring_in = 4'b0000; rev_clr = 1'b0;
      model_reset();
      #12;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({idx_o[k], valid_o[k], locked_o[k], oe_o[k], se_o[k]} !== 6'b0 || get_cnt(k) != 0) begin
            bad++;
            $display("FAIL reset[%0d]: idx=%0d valid=%b locked=%b oe=%b se=%b cnt=%0d, want all 0",
                     k, idx_o[k], valid_o[k], locked_o[k], oe_o[k], se_o[k], get_cnt(k));
         end
      end
      @(negedge clk);
      clear = 1'b1;
   endtask

   task automatic test_rotation();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int         exp_idx [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         step(1'b1, seq[i], 1'b0);
         total++;
         if (valid_o[0] !== 1'b1 || int'(idx_o[0]) != exp_idx[i] || oe_o[0] !== 1'b0 || se_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL rotation[%0d]: valid=%b idx=%0d oe=%b se=%b, want valid=1 idx=%0d oe=0 se=0",
                     i, valid_o[0], idx_o[0], oe_o[0], se_o[0], exp_idx[i]);
         end
         total++;
         if (get_cnt(0) != ((i == 4) ? 1 : 0)) begin
            bad++;
            $display("FAIL rotation_cnt[%0d]: got %0d want %0d", i, get_cnt(0), (i == 4) ? 1 : 0);
         end
      end
   endtask

   task automatic test_seq_err();
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      total++;
      if (se_o[0] !== 1'b1 || oe_o[0] !== 1'b0 || idx_o[0] !== 2'd3 || locked_o[0] !== 1'b1 || cnt0 !== 8'd1) begin
         bad++;
         $display("FAIL seq_err: se=%b oe=%b idx=%0d locked=%b cnt=%0d, want se=1 oe=0 idx=3 locked=1 cnt=1",
                  se_o[0], oe_o[0], idx_o[0], locked_o[0], cnt0);
      end
      step(1'b0, 4'b0110, 1'b0);
      total++;
      if (se_o[0] !== 1'b0 || oe_o[0] !== 1'b0 || idx_o[0] !== 2'd3) begin
         bad++;
         $display("FAIL seq_err_single: se=%b oe=%b idx=%0d, want se=0 oe=0 idx=3", se_o[0], oe_o[0], idx_o[0]);
      end
   endtask

   task automatic test_onehot_err();
      step(1'b1, 4'b0001, 1'b0);
      total++;
      if (cnt0 !== 8'd2 || idx_o[0] !== 2'd0) begin
         bad++;
         $display("FAIL wrap_after_reloc: cnt=%0d idx=%0d, want cnt=2 idx=0", cnt0, idx_o[0]);
      end
      step(1'b1, 4'b0110, 1'b0);
      total++;
      if (oe_o[0] !== 1'b1 || se_o[0] !== 1'b0 || locked_o[0] !== 1'b0 || valid_o[0] !== 1'b0 || idx_o[0] !== 2'd0) begin
         bad++;
         $display("FAIL onehot_err_multi: oe=%b se=%b locked=%b valid=%b idx=%0d, want oe=1 se=0 locked=0 valid=0 idx=0",
                  oe_o[0], se_o[0], locked_o[0], valid_o[0], idx_o[0]);
      end
      step(1'b1, 4'b0000, 1'b0);
      total++;
      if (oe_o[0] !== 1'b1 || se_o[0] !== 1'b0 || locked_o[0] !== 1'b0 || idx_o[0] !== 2'd0) begin
         bad++;
         $display("FAIL onehot_err_zero: oe=%b se=%b locked=%b idx=%0d, want oe=1 se=0 locked=0 idx=0",
                  oe_o[0], se_o[0], locked_o[0], idx_o[0]);
      end
   endtask

   task automatic test_hold();
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      total++;
      if (se_o[0] !== 1'b1 || idx_o[0] !== 2'd2 || locked_o[0] !== 1'b1) begin
         bad++;
         $display("FAIL hold_disallowed: se=%b idx=%0d locked=%b, want se=1 idx=2 locked=1", se_o[0], idx_o[0], locked_o[0]);
      end
      total++;
      if (se_o[1] !== 1'b0 || oe_o[1] !== 1'b0 || idx_o[1] !== 2'd2 || locked_o[1] !== 1'b1) begin
         bad++;
         $display("FAIL hold_allowed: se=%b oe=%b idx=%0d locked=%b, want se=0 oe=0 idx=2 locked=1",
                  se_o[1], oe_o[1], idx_o[1], locked_o[1]);
      end
   endtask

   task automatic test_saturation();
      logic [3:0] rev [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      int         exp_cnt [5] = '{1, 2, 3, 3, 3};
      #1 clear = 1'b0;
      #1 clear = 1'b1;
      model_reset();
      step(1'b1, 4'b0001, 1'b0);
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < 4; j++) step(1'b1, rev[j], 1'b0);
         total++;
         if (int'(cnt2) != exp_cnt[r]) begin
            bad++;
            $display("FAIL saturate[%0d]: got %0d want %0d", r, cnt2, exp_cnt[r]);
         end
      end
      for (int j = 0; j < 3; j++) step(1'b1, rev[j], 1'b0);
      step(1'b1, 4'b0001, 1'b1);
      total++;
      if (cnt2 !== 2'd0 || cnt0 !== 8'd0 || idx_o[2] !== 2'd0) begin
         bad++;
         $display("FAIL rev_clr_on_wrap: cnt2=%0d cnt0=%0d idx=%0d, want 0 0 0", cnt2, cnt0, idx_o[2]);
      end
   endtask

   task automatic test_clear_async();
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      #1 clear = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({idx_o[k], valid_o[k], locked_o[k], oe_o[k], se_o[k]} !== 6'b0 || get_cnt(k) != 0) begin
            bad++;
            $display("FAIL async_clear[%0d]: idx=%0d valid=%b locked=%b oe=%b se=%b cnt=%0d, want all 0",
                     k, idx_o[k], valid_o[k], locked_o[k], oe_o[k], se_o[k], get_cnt(k));
         end
      end
      @(negedge clk);
      clear = 1'b1;
      model_reset();
      step(1'b1, 4'b1000, 1'b0);
      total++;
      if (valid_o[0] !== 1'b1 || idx_o[0] !== 2'd3 || cnt0 !== 8'd0) begin
         bad++;
         $display("FAIL after_clear: valid=%b idx=%0d cnt=%0d, want valid=1 idx=3 cnt=0", valid_o[0], idx_o[0], cnt0);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      bit         e;
      bit         c;
      int         sel;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      r = 4'b0001 << ((m_pos[0] + 1) % 4);
         else if (sel < 7) r = 4'b0001 << m_pos[0];
         else              r = 4'($urandom);
         e = ($urandom_range(0, 9) < 8);
         c = e && ($urandom_range(0, 24) == 0);
         step(e, r, c);
         for (int k = 0; k < 3; k++) begin
            total++;
            if (int'(idx_o[k]) != m_pos[k] || valid_o[k] !== m_lock[k] || locked_o[k] !== m_lock[k] ||
                oe_o[k] !== m_oe[k] || se_o[k] !== m_se[k] || get_cnt(k) != m_cnt[k] ||
                (oe_o[k] === 1'b1 && se_o[k] === 1'b1)) begin
               bad++;
               $display("FAIL random[%0d][%0d]: idx=%0d v=%b l=%b oe=%b se=%b cnt=%0d, want idx=%0d v=%b l=%b oe=%b se=%b cnt=%0d",
                        n, k, idx_o[k], valid_o[k], locked_o[k], oe_o[k], se_o[k], get_cnt(k),
                        m_pos[k], m_lock[k], m_lock[k], m_oe[k], m_se[k], m_cnt[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_seq_err();
      test_onehot_err();
      test_hold();
      test_saturation();
      test_clear_async();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
